// File: rtl/gf_rom_arbiter.sv
// Round-robin arbiter sharing one GF power ROM and one GF decimal ROM among NREQ decoder sub-units.
// Burst locking, zero-bubble hand-over, and a one-hot rvalid tag on the 1-cycle registered ROM return.
module gf_rom_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    parameter int AW        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_pow_addr,
    input  logic [NREQ*AW-1:0]   req_dec_addr,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        rom_pow_addr,
    output logic [AW-1:0]        rom_dec_addr,
    input  logic [AW-1:0]        rom_pow_data,
    input  logic [AW-1:0]        rom_dec_data,
    output logic [AW-1:0]        rd_pow_data,
    output logic [AW-1:0]        rd_dec_data,
    output logic [NREQ-1:0]      rvalid,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 8;
    localparam logic [CW-1:0] CNT_MAX = (MAX_BURST > 0) ? CW'(MAX_BURST) : {CW{1'b1}};

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] rvalid_q;
    logic            busy_q;

    logic [IW-1:0]   sel;
    logic            sel_vld;
    logic [IW:0]     pick_idle, pick_hand;
    logic            others;
    logic            keep;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
        return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Returns {found, index}; scanning from the far end lets the lowest offset win.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
        logic [IW:0]   res;
        logic [IW-1:0] j;
        res = '0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            j = IW'((32'(p) + k - 1) % NREQ);
            if (r[j]) res = {1'b1, j};
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        sel       = owner_q;
        sel_vld   = 1'b0;
        pick_idle = rr_pick(req, ptr_q);
        pick_hand = rr_pick(req, nxt(owner_q));
        others    = |(req & ~(NREQ'(1) << owner_q));
        keep      = req[owner_q] && ((MAX_BURST == 0) || (cnt_q < CNT_MAX) || !others);

        if (reset && en) begin
            unique case (state_q)
                IDLE: begin
                    if (pick_idle[IW]) begin
                        sel     = pick_idle[IW-1:0];
                        sel_vld = 1'b1;
                        state_d = OWN;
                        owner_d = pick_idle[IW-1:0];
                        cnt_d   = CW'(1);
                        ptr_d   = nxt(pick_idle[IW-1:0]);
                    end
                end
                OWN: begin
                    if (keep) begin
                        sel_vld = 1'b1;
                        cnt_d   = (cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
                    end else if (pick_hand[IW]) begin
                        sel     = pick_hand[IW-1:0];
                        sel_vld = 1'b1;
                        owner_d = pick_hand[IW-1:0];
                        cnt_d   = CW'(1);
                        ptr_d   = nxt(pick_hand[IW-1:0]);
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        gnt          = '0;
        rom_pow_addr = '0;
        rom_dec_addr = '0;
        if (sel_vld) begin
            gnt          = NREQ'(1) << sel;
            rom_pow_addr = req_pow_addr[sel*AW +: AW];
            rom_dec_addr = req_dec_addr[sel*AW +: AW];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            rvalid_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt & req;
            busy_q   <= (state_d == OWN);
        end
    end

    assign rvalid      = rvalid_q;
    assign busy        = busy_q;
    assign rd_pow_data = rom_pow_data;
    assign rd_dec_data = rom_dec_data;

endmodule

// File: tb/tb_gf_rom_arbiter.sv
// Bench for gf_rom_arbiter: two instances (MAX_BURST=16 and MAX_BURST=1) on shared stimulus,
// each checked against an abstract arbitration model and a modelled registered ROM pair.
module tb_gf_rom_arbiter;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [3:0]      req = '0;
    logic [31:0]     pa = '0;
    logic [31:0]     da = '0;
    logic [1:0][3:0] gnt, rvalid;
    logic [1:0][7:0] rpa, rda, rpd, rdd, opd, odd;
    logic [1:0]      busy;

    int checks = 0;
    int errors = 0;

    int         mb[2] = '{16, 1};
    bit         m_own[2];
    int         m_ptr[2], m_owner[2], m_cnt[2];
    logic [3:0] m_rv[2], eg[2], g_obs[2];
    bit         ek[2];
    logic [7:0] m_pa[2], m_da[2];

    always #5 clk = ~clk;

    gf_rom_arbiter #(.NREQ(4), .MAX_BURST(16), .AW(8)) dut0 (
        .clk(clk), .reset(rst_n), .en(en), .req(req),
        .req_pow_addr(pa), .req_dec_addr(da), .gnt(gnt[0]),
        .rom_pow_addr(rpa[0]), .rom_dec_addr(rda[0]),
        .rom_pow_data(rpd[0]), .rom_dec_data(rdd[0]),
        .rd_pow_data(opd[0]), .rd_dec_data(odd[0]),
        .rvalid(rvalid[0]), .busy(busy[0])
    );

    gf_rom_arbiter #(.NREQ(4), .MAX_BURST(1), .AW(8)) dut1 (
        .clk(clk), .reset(rst_n), .en(en), .req(req),
        .req_pow_addr(pa), .req_dec_addr(da), .gnt(gnt[1]),
        .rom_pow_addr(rpa[1]), .rom_dec_addr(rda[1]),
        .rom_pow_data(rpd[1]), .rom_dec_data(rdd[1]),
        .rd_pow_data(opd[1]), .rd_dec_data(odd[1]),
        .rvalid(rvalid[1]), .busy(busy[1])
    );

    function automatic logic [7:0] fpow(input logic [7:0] a);
        return 8'(a * 8'd3 + 8'd1);
    endfunction

    function automatic logic [7:0] fdec(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    // Registered ROMs: data is the table value of last cycle's address.
    always @(posedge clk) begin
        rpd[0] <= fpow(rpa[0]);
        rdd[0] <= fdec(rda[0]);
        rpd[1] <= fpow(rpa[1]);
        rdd[1] <= fdec(rda[1]);
    end

    function automatic int rr(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (p + k) % 4;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [3:0] g);
        for (int k = 0; k < 4; k++) if (g[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = 0; m_ptr[i] = 0; m_owner[i] = 0; m_cnt[i] = 0;
            m_rv[i] = '0; m_pa[i] = '0; m_da[i] = '0;
        end
    endtask

    task automatic model_pick(input int i, input logic [3:0] r, output logic [3:0] g, output bit keep);
        int w;
        bit oth;
        g = '0;
        keep = 0;
        w = -1;
        if (en) begin
            if (!m_own[i]) begin
                w = rr(m_ptr[i], r);
            end else begin
                oth = (r & ~(4'b0001 << m_owner[i])) != 4'b0000;
                if (r[m_owner[i]] && (mb[i] == 0 || m_cnt[i] < mb[i] || !oth)) begin
                    keep = 1;
                    w = m_owner[i];
                end else begin
                    w = rr((m_owner[i] + 1) % 4, r);
                end
            end
            if (w >= 0) g = 4'b0001 << w;
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic e, input logic [31:0] p, input logic [31:0] d);
        int w;
        logic [7:0] ea, eda;
        req = r; en = e; pa = p; da = d;
        #1;
        for (int i = 0; i < 2; i++) begin
            model_pick(i, r, eg[i], ek[i]);
            w = idx_of(eg[i]);
            ea  = (w >= 0) ? pa[w*8 +: 8] : 8'h00;
            eda = (w >= 0) ? da[w*8 +: 8] : 8'h00;
            checks++;
            if (gnt[i] !== eg[i]) begin
                errors++;
                $display("FAIL gnt dut%0d t=%0t: got %b expected %b", i, $time, gnt[i], eg[i]);
            end
            checks++;
            if (rpa[i] !== ea) begin
                errors++;
                $display("FAIL rom_pow_addr dut%0d t=%0t: got %h expected %h", i, $time, rpa[i], ea);
            end
            checks++;
            if (rda[i] !== eda) begin
                errors++;
                $display("FAIL rom_dec_addr dut%0d t=%0t: got %h expected %h", i, $time, rda[i], eda);
            end
            g_obs[i] = gnt[i];
            m_pa[i] = ea;
            m_da[i] = eda;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = eg[i] & r;
            if (e) begin
                if (eg[i] == 4'b0000) begin
                    m_own[i] = 0;
                end else if (ek[i]) begin
                    if (mb[i] == 0 || m_cnt[i] < mb[i]) m_cnt[i]++;
                end else begin
                    w = idx_of(eg[i]);
                    m_own[i] = 1; m_owner[i] = w; m_cnt[i] = 1; m_ptr[i] = (w + 1) % 4;
                end
            end
            checks++;
            if (rvalid[i] !== m_rv[i]) begin
                errors++;
                $display("FAIL rvalid dut%0d t=%0t: got %b expected %b", i, $time, rvalid[i], m_rv[i]);
            end
            checks++;
            if (busy[i] !== m_own[i]) begin
                errors++;
                $display("FAIL busy dut%0d t=%0t: got %b expected %b", i, $time, busy[i], m_own[i]);
            end
            checks++;
            if (opd[i] !== fpow(m_pa[i]) || odd[i] !== fdec(m_da[i])) begin
                errors++;
                $display("FAIL rd_data dut%0d t=%0t: got %h/%h expected %h/%h", i, $time,
                         opd[i], odd[i], fpow(m_pa[i]), fdec(m_da[i]));
            end
        end
        @(negedge clk);
    endtask

    task automatic rcycle(input logic [3:0] r, input logic e);
        cycle(r, e, $urandom, $urandom);
    endtask

    // Asserted mid-cycle with req/en still active, so gating of gnt is exercised.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (gnt[i] !== 4'b0000 || rvalid[i] !== 4'b0000 || busy[i] !== 1'b0 || rpa[i] !== 8'h00) begin
                errors++;
                $display("FAIL async_reset dut%0d: got gnt=%b rvalid=%b busy=%b addr=%h expected 0000/0000/0/00",
                         i, gnt[i], rvalid[i], busy[i], rpa[i]);
            end
        end
        req = '0;
        en = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        en = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (gnt[i] !== 4'b0000 || rvalid[i] !== 4'b0000 || busy[i] !== 1'b0 || rpa[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_state dut%0d: got gnt=%b rvalid=%b busy=%b addr=%h expected 0000/0000/0/00",
                         i, gnt[i], rvalid[i], busy[i], rpa[i]);
            end
        end
        rst_n = 1'b1;
        rcycle(4'b0000, 1'b1);
    endtask

    task automatic test_single();
        cycle(4'b0010, 1'b1, 32'h0000_0500, $urandom);
        cycle(4'b0010, 1'b1, 32'h0000_0600, $urandom);
        cycle(4'b0010, 1'b1, 32'h0000_0700, $urandom);
        rcycle(4'b0000, 1'b1);
        rcycle(4'b0000, 1'b1);
    endtask

    task automatic test_fairness();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            rcycle(4'b1111, 1'b1);
            checks++;
            if (g_obs[1] !== (4'b0001 << exp_order[k])) begin
                errors++;
                $display("FAIL fairness_order beat %0d: got %b expected %b", k, g_obs[1], 4'b0001 << exp_order[k]);
            end
        end
        rcycle(4'b0000, 1'b1);
    endtask

    task automatic test_burst_lock();
        int n0 = 0;
        bit seen2 = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            rcycle((c < 3) ? 4'b0001 : (c <= 16) ? 4'b0101 : 4'b0001, 1'b1);
            if (!seen2 && g_obs[0] == 4'b0001) n0++;
            if (g_obs[0] == 4'b0100) seen2 = 1;
        end
        checks++;
        if (n0 != 16 || !seen2) begin
            errors++;
            $display("FAIL burst_lock: got %0d owner beats (handover=%0d) expected 16 (handover=1)", n0, seen2);
        end
        rcycle(4'b0000, 1'b1);
    endtask

    task automatic test_owner_release();
        do_reset();
        rcycle(4'b0100, 1'b1);
        rcycle(4'b1101, 1'b1);
        rcycle(4'b1001, 1'b1);
        checks++;
        if (g_obs[0] !== 4'b1000) begin
            errors++;
            $display("FAIL owner_release: got %b expected 1000", g_obs[0]);
        end
        rcycle(4'b0001, 1'b1);
        rcycle(4'b0000, 1'b1);
    endtask

    task automatic test_enable();
        do_reset();
        for (int c = 0; c < 5; c++) rcycle(4'b0010, 1'b1);
        rcycle(4'b1010, 1'b0);
        rcycle(4'b1010, 1'b0);
        for (int c = 0; c < 14; c++) rcycle(4'b1010, 1'b1);
        rcycle(4'b0000, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) rcycle(4'b0010, 1'b1);
        req = 4'b0010;
        en = 1'b1;
        do_reset();
        rcycle(4'b0100, 1'b1);
        rcycle(4'b0000, 1'b1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++)
            rcycle(4'($urandom), ($urandom % 8) != 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_burst_lock();
        test_owner_release();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
